wakeup_issue_queue: RTL and testbench
=====================================

Name: wakeup_issue_queue

Overview:
Parametrised successor to the single-FU issue queue: holds up to QUEUE_DEPTH renamed instructions for one functional unit, tracks per-operand readiness from WAKE_PORTS result broadcast channels, and issues the oldest ready entry through a registered valid/ready stage. It sits between the instruction router and an FU, and drives the PRF read ports for the issuing instruction. Adds age-ordered select, FU backpressure, flush, and a selectable in-order mode.

Parameters:
INST_ID_BITS, 6, instruction ID width
PRN_BITS, 6, physical register number width
MAX_OPERANDS, 3, source/destination operand slots per instruction
QUEUE_DEPTH, 4, entry count (>=2, any integer)
WAKE_PORTS, 4, number of PRN wakeup broadcast channels
IN_ORDER, 0, 1 = only the oldest entry may issue

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
flush  input  1  discard all entries and the output stage
enq_valid  input  1  router offers an instruction
enq_ready  output  1  queue can accept
enq_inst_id  input  INST_ID_BITS  instruction ID
enq_raw_instr  input  32  encoded instruction
enq_pc  input  64  instruction PC
enq_src_valid  input  [MAX_OPERANDS]x1  source slot used
enq_src_ready  input  [MAX_OPERANDS]x1  source already readable in PRF
enq_src_prn  input  [MAX_OPERANDS]xPRN_BITS  source PRNs
enq_dst_valid  input  [MAX_OPERANDS]x1  destination slot used
enq_dst_prn  input  [MAX_OPERANDS]xPRN_BITS  destination PRNs
wake_valid  input  [WAKE_PORTS][MAX_OPERANDS]x1  broadcast valid
wake_prn  input  [WAKE_PORTS][MAX_OPERANDS]xPRN_BITS  broadcast PRN
iss_valid  output  1  output stage holds an instruction
iss_ready  input  1  FU accepts
iss_inst_id / iss_raw_instr / iss_pc / iss_dst_valid / iss_dst_prn  output  as enq  issued instruction fields
prf_read_enable  output  [MAX_OPERANDS]x1  = iss_valid && iss source slot used
prf_read_prn  output  [MAX_OPERANDS]xPRN_BITS  output-stage source PRNs
occupancy  output  $clog2(QUEUE_DEPTH+1)  valid entry count (excludes output stage)

Behaviour:
- Reset/flush: all entry valids, output stage, occupancy cleared; iss_valid=0, prf_read_enable=0, enq_ready=1. Reset is async; flush acts on the clock edge and drops any same-cycle enqueue and issue.
- enq_ready = occupancy < QUEUE_DEPTH, registered-state only; a same-cycle dequeue does not raise it.
- Enqueue on enq_valid && enq_ready: write lowest-index free entry; entry becomes younger than all valid entries. Source ready bit = !src_valid || src_ready || any same-cycle wake match.
- Wakeup: every cycle, each valid entry sets a source ready bit if any wake_valid[p][k] with wake_prn[p][k] equal to its PRN. Ready bits are registered; entry is selectable the cycle after the wake.
- Select (comb): candidates = valid entries with all sources ready; IN_ORDER=1 restricts to the oldest valid entry (blocks if not ready). Pick oldest candidate via age matrix.
- Advance: when output stage empty or iss_ready, selected entry moves to output stage and its entry is freed on that edge. Minimum latency: enqueue of fully ready instruction at edge N -> iss_valid from edge N+1.
- Backpressure: iss_valid && !iss_ready holds all iss_* and prf_read_* stable.
- Simultaneous enqueue and dequeue in a full-minus-one or full queue: both occur; occupancy unchanged net.
- Age matrix: row i bit j = entry j older than i; on enqueue row set to current valid vector, column cleared.

Decomposition:
- Shared package (foxtrot_iq_pkg): iq_entry_t struct (id, instr, pc, src/dst valid, prn, ready), wake bus typedef, $clog2 width constants.
- Sub-module age_matrix_select: QUEUE_DEPTH age matrix, enqueue/free update, one-hot oldest-of-request output.

Test Plan:
- Reset mid-enqueue, then enq ID 5 with all sources ready at edge 1 -> iss_valid=1 after edge 2, iss_inst_id=5, prf_read_prn = its sources.
- Enq ID 3 src PRN 12 not ready; wake_valid[2][1]=1, wake_prn=12 at cycle 4 -> iss_valid first cycle 6, not earlier.
- Enq IDs 1,2,3 (1 waits on PRN 9, 2,3 ready) -> issue order 2,3; wake 9 -> 1. With IN_ORDER=1 -> nothing issues until wake 9, then 1,2,3.
- Fill 4 entries with iss_ready=0 -> enq_ready=0, occupancy=4; raise iss_ready and enq together -> accepted only the cycle after a dequeue.
- Hold iss_ready=0 for 5 cycles with iss_valid=1 -> all iss_* stable; release -> next oldest ready follows back-to-back.
- flush with 3 entries plus valid output and concurrent enq -> next cycle occupancy=0, iss_valid=0, enqueued instruction absent.

Source files
------------

// File: rtl/wakeup_issue_queue_pkg.sv
// Shared constants and helpers for the wakeup issue queue slice.
package wakeup_issue_queue_pkg;

  localparam int unsigned DEF_INST_ID_BITS = 6;
  localparam int unsigned DEF_PRN_BITS     = 6;
  localparam int unsigned DEF_MAX_OPERANDS = 3;
  localparam int unsigned DEF_QUEUE_DEPTH  = 4;
  localparam int unsigned DEF_WAKE_PORTS   = 4;
  localparam int unsigned INSTR_W          = 32;
  localparam int unsigned PC_W             = 64;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wakeup_issue_queue_if.sv
// Router/FU/wakeup bundle of the issue queue; slave = queue, master = environment.
interface wakeup_issue_queue_if
  import wakeup_issue_queue_pkg::*;
#(
  parameter int unsigned INST_ID_BITS = DEF_INST_ID_BITS,
  parameter int unsigned PRN_BITS     = DEF_PRN_BITS,
  parameter int unsigned MAX_OPERANDS = DEF_MAX_OPERANDS,
  parameter int unsigned QUEUE_DEPTH  = DEF_QUEUE_DEPTH,
  parameter int unsigned WAKE_PORTS   = DEF_WAKE_PORTS
);
  localparam int unsigned OCC_W = occ_width(QUEUE_DEPTH);

  logic                                                  flush;
  logic                                                  enq_valid;
  logic                                                  enq_ready;
  logic [INST_ID_BITS-1:0]                               enq_inst_id;
  logic [INSTR_W-1:0]                                    enq_raw_instr;
  logic [PC_W-1:0]                                       enq_pc;
  logic [MAX_OPERANDS-1:0]                               enq_src_valid;
  logic [MAX_OPERANDS-1:0]                               enq_src_ready;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                 enq_src_prn;
  logic [MAX_OPERANDS-1:0]                               enq_dst_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                 enq_dst_prn;
  logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0]               wake_valid;
  logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] wake_prn;
  logic                                                  iss_valid;
  logic                                                  iss_ready;
  logic [INST_ID_BITS-1:0]                               iss_inst_id;
  logic [INSTR_W-1:0]                                    iss_raw_instr;
  logic [PC_W-1:0]                                       iss_pc;
  logic [MAX_OPERANDS-1:0]                               iss_dst_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                 iss_dst_prn;
  logic [MAX_OPERANDS-1:0]                               prf_read_enable;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                 prf_read_prn;
  logic [OCC_W-1:0]                                      occupancy;

  modport slave (
    input  flush, enq_valid, enq_inst_id, enq_raw_instr, enq_pc,
           enq_src_valid, enq_src_ready, enq_src_prn, enq_dst_valid, enq_dst_prn,
           wake_valid, wake_prn, iss_ready,
    output enq_ready, iss_valid, iss_inst_id, iss_raw_instr, iss_pc,
           iss_dst_valid, iss_dst_prn, prf_read_enable, prf_read_prn, occupancy
  );

  modport master (
    output flush, enq_valid, enq_inst_id, enq_raw_instr, enq_pc,
           enq_src_valid, enq_src_ready, enq_src_prn, enq_dst_valid, enq_dst_prn,
           wake_valid, wake_prn, iss_ready,
    input  enq_ready, iss_valid, iss_inst_id, iss_raw_instr, iss_pc,
           iss_dst_valid, iss_dst_prn, prf_read_enable, prf_read_prn, occupancy
  );

endinterface

// File: rtl/wakeup_issue_queue_age_matrix_select.sv
// Age matrix: row i bit j set means entry j is older than entry i.
// Grants the single oldest requester as a one-hot vector.
module age_matrix_select #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] valid_i,
  input  logic [DEPTH-1:0] enq_oh_i,
  input  logic [DEPTH-1:0] free_oh_i,
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] grant_o
);

  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;

  // New entry is younger than everything valid; nobody may count it as older.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (enq_oh_i[i]) begin
        age_d[i] = valid_i;
        for (int r = 0; r < DEPTH; r++) age_d[r][i] = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (free_oh_i[i]) begin
        for (int r = 0; r < DEPTH; r++) age_d[r][i] = 1'b0;
      end
    end
  end

  // Age matrix state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end

  // A requester wins when no other requester is older than it.
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant_o[i] = req_i[i] && ((age_q[i] & req_i) == '0);
    end
  end

endmodule

// File: rtl/wakeup_issue_queue.sv
// Wakeup issue queue for one FU: tracks operand readiness from result
// broadcasts and issues the oldest ready entry through a registered stage.
module wakeup_issue_queue
  import wakeup_issue_queue_pkg::*;
#(
  parameter int unsigned INST_ID_BITS = DEF_INST_ID_BITS,
  parameter int unsigned PRN_BITS     = DEF_PRN_BITS,
  parameter int unsigned MAX_OPERANDS = DEF_MAX_OPERANDS,
  parameter int unsigned QUEUE_DEPTH  = DEF_QUEUE_DEPTH,
  parameter int unsigned WAKE_PORTS   = DEF_WAKE_PORTS,
  parameter int unsigned IN_ORDER     = 0
) (
  input  logic                clk,
  input  logic                rst,
  wakeup_issue_queue_if.slave bus
);

  localparam int unsigned OCC_W = occ_width(QUEUE_DEPTH);

  typedef struct packed {
    logic [INST_ID_BITS-1:0]               id;
    logic [INSTR_W-1:0]                    instr;
    logic [PC_W-1:0]                       pc;
    logic [MAX_OPERANDS-1:0]               src_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] src_prn;
    logic [MAX_OPERANDS-1:0]               src_rdy;
    logic [MAX_OPERANDS-1:0]               dst_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] dst_prn;
  } iq_entry_t;

  iq_entry_t [QUEUE_DEPTH-1:0] ent_q, ent_d;
  logic      [QUEUE_DEPTH-1:0] vld_q, vld_d;
  iq_entry_t                   out_q, out_d;
  logic                        out_vld_q, out_vld_d;

  logic [OCC_W-1:0]       occ;
  logic [QUEUE_DEPTH-1:0] free_oh, cand, req, grant, sel;
  logic                   enq_fire, adv;
  iq_entry_t              new_ent, sel_ent;

  function automatic logic wake_hit(
    input logic [PRN_BITS-1:0]                               prn,
    input logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0]               wv,
    input logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] wp
  );
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++)
      for (int k = 0; k < MAX_OPERANDS; k++)
        if (wv[p][k] && (wp[p][k] == prn)) hit = 1'b1;
    return hit;
  endfunction

  // Occupancy from registered valids only, so a same-cycle dequeue never opens enq_ready.
  always_comb begin
    occ = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) occ = occ + OCC_W'(vld_q[i]);
  end

  assign bus.occupancy = occ;
  assign bus.enq_ready = (occ < OCC_W'(QUEUE_DEPTH));
  assign enq_fire      = bus.enq_valid && bus.enq_ready;
  // Lowest clear bit of the valid vector (all-zero when full).
  assign free_oh       = ~vld_q & (vld_q + QUEUE_DEPTH'(1));

  // Build the incoming entry; a broadcast in the enqueue cycle counts immediately.
  always_comb begin
    new_ent.id        = bus.enq_inst_id;
    new_ent.instr     = bus.enq_raw_instr;
    new_ent.pc        = bus.enq_pc;
    new_ent.src_valid = bus.enq_src_valid;
    new_ent.src_prn   = bus.enq_src_prn;
    new_ent.dst_valid = bus.enq_dst_valid;
    new_ent.dst_prn   = bus.enq_dst_prn;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      new_ent.src_rdy[k] = !bus.enq_src_valid[k] || bus.enq_src_ready[k] ||
                           wake_hit(bus.enq_src_prn[k], bus.wake_valid, bus.wake_prn);
    end
  end

  // Candidates use registered ready bits; in-order mode only lets the oldest valid entry compete.
  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH; i++) cand[i] = vld_q[i] && (&ent_q[i].src_rdy);
    req = (IN_ORDER != 0) ? vld_q : cand;
  end

  age_matrix_select #(.DEPTH(QUEUE_DEPTH)) u_age (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (vld_q),
    .enq_oh_i  (enq_fire ? free_oh : '0),
    .free_oh_i (adv ? sel : '0),
    .req_i     (req),
    .grant_o   (grant)
  );

  assign sel = grant & cand;
  assign adv = (|sel) && (!out_vld_q || bus.iss_ready);

  // One-hot mux of the selected entry.
  always_comb begin
    sel_ent = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) if (sel[i]) sel_ent = ent_q[i];
  end

  // Entry next state: wakeups, free on advance, fill on enqueue; flush wins.
  always_comb begin
    vld_d = vld_q;
    ent_d = ent_q;
    for (int i = 0; i < QUEUE_DEPTH; i++)
      for (int k = 0; k < MAX_OPERANDS; k++)
        if (vld_q[i] && wake_hit(ent_q[i].src_prn[k], bus.wake_valid, bus.wake_prn))
          ent_d[i].src_rdy[k] = 1'b1;
    if (adv) vld_d = vld_d & ~sel;
    if (enq_fire) begin
      vld_d = vld_d | free_oh;
      for (int i = 0; i < QUEUE_DEPTH; i++) if (free_oh[i]) ent_d[i] = new_ent;
    end
    if (bus.flush) vld_d = '0;
  end

  // Output stage next state: load on advance, drain on FU accept, hold under backpressure.
  always_comb begin
    out_vld_d = out_vld_q;
    out_d     = out_q;
    if (adv) begin
      out_vld_d = 1'b1;
      out_d     = sel_ent;
    end else if (out_vld_q && bus.iss_ready) begin
      out_vld_d = 1'b0;
    end
    if (bus.flush) out_vld_d = 1'b0;
  end

  // Control state: valids only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      out_vld_q <= out_vld_d;
    end
  end

  // Payload state: qualified by the valids, so no reset needed.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
    out_q <= out_d;
  end

  assign bus.iss_valid       = out_vld_q;
  assign bus.iss_inst_id     = out_q.id;
  assign bus.iss_raw_instr   = out_q.instr;
  assign bus.iss_pc          = out_q.pc;
  assign bus.iss_dst_valid   = out_q.dst_valid;
  assign bus.iss_dst_prn     = out_q.dst_prn;
  assign bus.prf_read_enable = {MAX_OPERANDS{out_vld_q}} & out_q.src_valid;
  assign bus.prf_read_prn    = out_q.src_prn;

endmodule

// File: tb/tb_wakeup_issue_queue.sv
// Scoreboard bench: stimulus pushes expected issues, negedge monitors pop on each FU handshake.
module tb_wakeup_issue_queue;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic b_en = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wakeup_issue_queue_if ifa ();
  wakeup_issue_queue_if ifb ();

  wakeup_issue_queue #(.IN_ORDER(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  wakeup_issue_queue #(.IN_ORDER(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // The in-order instance mirrors A's stimulus only while b_en is set; otherwise it is held flushed.
  assign ifb.flush         = ifa.flush | ~b_en;
  assign ifb.enq_valid     = ifa.enq_valid & b_en;
  assign ifb.enq_inst_id   = ifa.enq_inst_id;
  assign ifb.enq_raw_instr = ifa.enq_raw_instr;
  assign ifb.enq_pc        = ifa.enq_pc;
  assign ifb.enq_src_valid = ifa.enq_src_valid;
  assign ifb.enq_src_ready = ifa.enq_src_ready;
  assign ifb.enq_src_prn   = ifa.enq_src_prn;
  assign ifb.enq_dst_valid = ifa.enq_dst_valid;
  assign ifb.enq_dst_prn   = ifa.enq_dst_prn;
  assign ifb.wake_valid    = ifa.wake_valid;
  assign ifb.wake_prn      = ifa.wake_prn;
  assign ifb.iss_ready     = ifa.iss_ready;

  typedef struct packed {
    logic [5:0]  id;
    logic [31:0] raw;
    logic [63:0] pc;
    logic [2:0]  rd_en;
    logic [17:0] src;
    logic [2:0]  dv;
    logic [17:0] dp;
  } exp_t;

  exp_t expq_a[$];
  exp_t expq_b[$];
  exp_t ea, eb;

  function automatic exp_t mk(input logic [5:0] id, input logic [2:0] sv,
                              input logic [5:0] p0, input logic [5:0] p1, input logic [5:0] p2);
    exp_t e;
    e.id    = id;
    e.raw   = 32'hC0DE_0000 | {26'd0, id};
    e.pc    = 64'h8000_0000 + {56'd0, id, 2'b00};
    e.rd_en = sv;
    e.src   = {p2, p1, p0};
    e.dv    = 3'b001;
    e.dp    = {6'd0, 6'd0, id + 6'd32};
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic [5:0] id, input logic [2:0] sv, input logic [2:0] sr,
                           input logic [5:0] p0, input logic [5:0] p1, input logic [5:0] p2);
    exp_t e;
    e = mk(id, sv, p0, p1, p2);
    ifa.enq_valid     = 1'b1;
    ifa.enq_inst_id   = id;
    ifa.enq_raw_instr = e.raw;
    ifa.enq_pc        = e.pc;
    ifa.enq_src_valid = sv;
    ifa.enq_src_ready = sr;
    ifa.enq_src_prn   = {p2, p1, p0};
    ifa.enq_dst_valid = e.dv;
    ifa.enq_dst_prn   = e.dp;
  endtask

  task automatic clr_enq();
    ifa.enq_valid     = 1'b0;
    ifa.enq_inst_id   = '0;
    ifa.enq_raw_instr = '0;
    ifa.enq_pc        = '0;
    ifa.enq_src_valid = '0;
    ifa.enq_src_ready = '0;
    ifa.enq_src_prn   = '0;
    ifa.enq_dst_valid = '0;
    ifa.enq_dst_prn   = '0;
  endtask

  task automatic set_wake(input int p, input int k, input logic [5:0] prn);
    ifa.wake_valid[p][k] = 1'b1;
    ifa.wake_prn[p][k]   = prn;
  endtask

  task automatic clr_wake();
    ifa.wake_valid = '0;
    ifa.wake_prn   = '0;
  endtask

  // Monitor for the out-of-order instance.
  always @(negedge clk) begin
    if (!rst && ifa.iss_valid && ifa.iss_ready) begin
      if (expq_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected_issue actual_id=%0d required=none", ifa.iss_inst_id);
      end else begin
        ea = expq_a.pop_front();
        chk("a_iss_id", 64'(ifa.iss_inst_id), 64'(ea.id));
        chk("a_iss_raw", 64'(ifa.iss_raw_instr), 64'(ea.raw));
        chk("a_iss_pc", ifa.iss_pc, ea.pc);
        chk("a_prf_en", 64'(ifa.prf_read_enable), 64'(ea.rd_en));
        chk("a_prf_prn", 64'(ifa.prf_read_prn), 64'(ea.src));
        chk("a_dst", 64'({ifa.iss_dst_valid, ifa.iss_dst_prn}), 64'({ea.dv, ea.dp}));
      end
    end
  end

  // Monitor for the in-order instance.
  always @(negedge clk) begin
    if (!rst && b_en && ifb.iss_valid && ifb.iss_ready) begin
      if (expq_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected_issue actual_id=%0d required=none", ifb.iss_inst_id);
      end else begin
        eb = expq_b.pop_front();
        chk("b_iss_id", 64'(ifb.iss_inst_id), 64'(eb.id));
        chk("b_prf_prn", 64'(ifb.prf_read_prn), 64'(eb.src));
      end
    end
  end

  initial begin
    ifa.flush     = 1'b0;
    ifa.iss_ready = 1'b1;
    clr_wake();
    // Reset arrives while an enqueue is being offered; ID 7 must vanish.
    drive_enq(6'd7, 3'b001, 3'b001, 6'd3, 6'd0, 6'd0);
    #2 rst = 1'b1;
    tick();
    tick();
    chk("rst_iss_valid", 64'(ifa.iss_valid), 64'd0);
    chk("rst_enq_ready", 64'(ifa.enq_ready), 64'd1);
    chk("rst_occupancy", 64'(ifa.occupancy), 64'd0);
    chk("rst_prf_en", 64'(ifa.prf_read_enable), 64'd0);
    rst = 1'b0;

    // Fully ready ID 5: enqueued at edge 1, visible after edge 2.
    drive_enq(6'd5, 3'b011, 3'b011, 6'd1, 6'd2, 6'd0);
    expq_a.push_back(mk(6'd5, 3'b011, 6'd1, 6'd2, 6'd0));
    tick();
    clr_enq();
    chk("t1_occ_after_enq", 64'(ifa.occupancy), 64'd1);
    chk("t1_not_yet_valid", 64'(ifa.iss_valid), 64'd0);
    tick();
    chk("t1_iss_valid", 64'(ifa.iss_valid), 64'd1);
    chk("t1_iss_id", 64'(ifa.iss_inst_id), 64'd5);
    tick();
    chk("t1_drained", 64'(ifa.iss_valid), 64'd0);

    // ID 3 waits on PRN 12, woken on port 2 slot 1 during cycle 4.
    drive_enq(6'd3, 3'b001, 3'b000, 6'd12, 6'd0, 6'd0);
    expq_a.push_back(mk(6'd3, 3'b001, 6'd12, 6'd0, 6'd0));
    tick();
    clr_enq();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t2_wait", 64'(ifa.iss_valid), 64'd0);
    end
    set_wake(2, 1, 6'd12);
    tick();
    clr_wake();
    chk("t2_not_early", 64'(ifa.iss_valid), 64'd0);
    tick();
    chk("t2_iss_valid", 64'(ifa.iss_valid), 64'd1);
    chk("t2_iss_id", 64'(ifa.iss_inst_id), 64'd3);
    tick();

    // IDs 1 (waits PRN 9), 2, 3: A issues 2,3,1; in-order B issues 1,2,3.
    b_en = 1'b1;
    expq_a.push_back(mk(6'd2, 3'b001, 6'd4, 6'd0, 6'd0));
    expq_a.push_back(mk(6'd3, 3'b001, 6'd5, 6'd0, 6'd0));
    expq_a.push_back(mk(6'd1, 3'b001, 6'd9, 6'd0, 6'd0));
    expq_b.push_back(mk(6'd1, 3'b001, 6'd9, 6'd0, 6'd0));
    expq_b.push_back(mk(6'd2, 3'b001, 6'd4, 6'd0, 6'd0));
    expq_b.push_back(mk(6'd3, 3'b001, 6'd5, 6'd0, 6'd0));
    drive_enq(6'd1, 3'b001, 3'b000, 6'd9, 6'd0, 6'd0);
    tick();
    drive_enq(6'd2, 3'b001, 3'b001, 6'd4, 6'd0, 6'd0);
    tick();
    drive_enq(6'd3, 3'b001, 3'b001, 6'd5, 6'd0, 6'd0);
    tick();
    clr_enq();
    chk("t3_a_first", 64'(ifa.iss_inst_id), 64'd2);
    chk("t3_b_blocked0", 64'(ifb.iss_valid), 64'd0);
    tick();
    chk("t3_a_second", 64'(ifa.iss_inst_id), 64'd3);
    chk("t3_b_blocked1", 64'(ifb.iss_valid), 64'd0);
    tick();
    chk("t3_a_idle", 64'(ifa.iss_valid), 64'd0);
    chk("t3_a_occ", 64'(ifa.occupancy), 64'd1);
    chk("t3_b_occ", 64'(ifb.occupancy), 64'd3);
    set_wake(1, 2, 6'd9);
    tick();
    clr_wake();
    chk("t3_a_not_early", 64'(ifa.iss_valid), 64'd0);
    tick();
    chk("t3_a_third", 64'(ifa.iss_inst_id), 64'd1);
    chk("t3_b_first", 64'(ifb.iss_inst_id), 64'd1);
    tick();
    chk("t3_b_second", 64'(ifb.iss_inst_id), 64'd2);
    tick();
    chk("t3_b_third", 64'(ifb.iss_inst_id), 64'd3);
    tick();
    chk("t3_b_idle", 64'(ifb.iss_valid), 64'd0);
    b_en = 1'b0;

    // Fill with FU stalled: 10 in output stage, 11..14 fill all four entries.
    ifa.iss_ready = 1'b0;
    for (int n = 10; n <= 14; n++) begin
      drive_enq(6'(n), 3'b011, 3'b011, 6'(n), 6'(n + 1), 6'd0);
      expq_a.push_back(mk(6'(n), 3'b011, 6'(n), 6'(n + 1), 6'd0));
      tick();
    end
    chk("t4_full_occ", 64'(ifa.occupancy), 64'd4);
    chk("t4_full_enq_ready", 64'(ifa.enq_ready), 64'd0);
    drive_enq(6'd15, 3'b011, 3'b011, 6'd15, 6'd16, 6'd0);
    expq_a.push_back(mk(6'd15, 3'b011, 6'd15, 6'd16, 6'd0));
    tick();
    chk("t4_refused_occ", 64'(ifa.occupancy), 64'd4);
    ifa.iss_ready = 1'b1;
    tick();
    chk("t4_deq_occ", 64'(ifa.occupancy), 64'd3);
    chk("t4_deq_enq_ready", 64'(ifa.enq_ready), 64'd1);
    chk("t4_deq_iss_id", 64'(ifa.iss_inst_id), 64'd11);
    tick();
    clr_enq();
    ifa.iss_ready = 1'b0;
    chk("t4_accept_occ", 64'(ifa.occupancy), 64'd3);

    // Backpressure: ID 12 must hold steady for five stalled cycles.
    for (int c = 0; c < 5; c++) begin
      chk("t5_hold_valid", 64'(ifa.iss_valid), 64'd1);
      chk("t5_hold_id", 64'(ifa.iss_inst_id), 64'd12);
      chk("t5_hold_prn", 64'(ifa.prf_read_prn), 64'({6'd0, 6'd13, 6'd12}));
      chk("t5_hold_pc", ifa.iss_pc, 64'h8000_0030);
      tick();
    end
    ifa.iss_ready = 1'b1;
    tick();
    chk("t5_b2b_13", 64'(ifa.iss_inst_id), 64'd13);
    tick();
    chk("t5_b2b_14", 64'(ifa.iss_inst_id), 64'd14);
    tick();
    chk("t5_b2b_15", 64'(ifa.iss_inst_id), 64'd15);
    tick();
    chk("t5_empty", 64'(ifa.iss_valid), 64'd0);

    // Flush with three entries, a held output stage and a concurrent enqueue.
    ifa.iss_ready = 1'b0;
    for (int n = 20; n <= 23; n++) begin
      drive_enq(6'(n), 3'b001, 3'b001, 6'(n), 6'd0, 6'd0);
      tick();
    end
    chk("t6_pre_occ", 64'(ifa.occupancy), 64'd3);
    chk("t6_pre_iss_id", 64'(ifa.iss_inst_id), 64'd20);
    drive_enq(6'd24, 3'b001, 3'b001, 6'd24, 6'd0, 6'd0);
    ifa.flush = 1'b1;
    tick();
    ifa.flush = 1'b0;
    clr_enq();
    chk("t6_occ", 64'(ifa.occupancy), 64'd0);
    chk("t6_iss_valid", 64'(ifa.iss_valid), 64'd0);
    chk("t6_enq_ready", 64'(ifa.enq_ready), 64'd1);
    chk("t6_prf_en", 64'(ifa.prf_read_enable), 64'd0);
    ifa.iss_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6_no_ghost", 64'(ifa.iss_valid), 64'd0);
    end
    drive_enq(6'd25, 3'b100, 3'b100, 6'd0, 6'd0, 6'd33);
    expq_a.push_back(mk(6'd25, 3'b100, 6'd0, 6'd0, 6'd33));
    tick();
    clr_enq();
    tick();
    chk("t6_after_flush_id", 64'(ifa.iss_inst_id), 64'd25);
    tick();
    tick();

    chk("a_queue_drained", 64'(expq_a.size()), 64'd0);
    chk("b_queue_drained", 64'(expq_b.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
